// File: rtl/iq_entry_allocator_pkg.sv
// ============================================================================
// iq_entry_allocator_pkg : shared sizing defaults and free-count width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package iq_entry_allocator_pkg;

  localparam int IQ_ENTRY_COUNT_DEF = 4;
  localparam int IQ_ENQ_WIDTH_DEF   = 2;
  localparam int IQ_DEQ_WIDTH_DEF   = 2;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int free_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_entry_allocator_picker.sv
// ============================================================================
// prio_onehot_picker : one-hot of the (rank+1)-th lowest set bit of vec
// Rev 1.0
// ============================================================================
`default_nettype none

module prio_onehot_picker #(
  parameter int Width = 4,
  parameter int RankW = 1
) (
  input  logic [Width-1:0] vec,
  input  logic [RankW-1:0] rank,
  output logic [Width-1:0] onehot
);

  always_comb begin
    int unsigned seen;
    seen   = 0;
    onehot = '0;
    for (int i = 0; i < Width; i++) begin
      if (vec[i] && (seen == 32'(rank))) onehot[i] = 1'b1;
      seen = seen + 32'(vec[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/iq_entry_allocator.sv
// ============================================================================
// iq_entry_allocator : multi-lane issue-queue entry allocation and release
// Rev 1.0
// ============================================================================
`default_nettype none

module iq_entry_allocator
  import iq_entry_allocator_pkg::*;
#(
  parameter int EntryCount = IQ_ENTRY_COUNT_DEF,
  parameter int EnqWidth   = IQ_ENQ_WIDTH_DEF,
  parameter int DeqWidth   = IQ_DEQ_WIDTH_DEF
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic [EnqWidth-1:0]                            alloc_req_i,
  output logic [EnqWidth-1:0]                            alloc_fire_o,
  output logic [EnqWidth-1:0][EntryCount-1:0]            alloc_mask_o,
  input  logic [DeqWidth-1:0]                            free_vld_i,
  input  logic [DeqWidth-1:0][EntryCount-1:0]            free_mask_i,
  input  logic                                           flush_i,
  output logic                                           deq_fire_o,
  output logic [EntryCount-1:0]                          deq_mask_o,
  output logic [EntryCount-1:0]                          entry_vld_o,
  output logic [free_cnt_width(EntryCount)-1:0]          free_cnt_o,
  output logic                                           full_o,
  output logic                                           empty_o
);

  localparam int CntW  = free_cnt_width(EntryCount);
  localparam int RankW = free_cnt_width(EnqWidth);

  logic [EntryCount-1:0] entry_vld_q;
  logic [EntryCount-1:0] entry_vld_d;
  logic [CntW-1:0]       free_cnt_q;
  logic [CntW-1:0]       free_cnt_d;
  logic [EntryCount-1:0] free_set;
  logic [EntryCount-1:0] alloc_or;
  logic [EntryCount-1:0] free_or;
  logic [RankW-1:0]      lane_rank [EnqWidth];
  logic [EntryCount-1:0] lane_pick [EnqWidth];
  logic                  free_overlap;

  // Only entries free at the start of the cycle are grantable.
  assign free_set = ~entry_vld_q;

  always_comb begin
    int unsigned below;
    below = 0;
    for (int j = 0; j < EnqWidth; j++) begin
      lane_rank[j] = RankW'(below);
      below        = below + 32'(alloc_req_i[j]);
    end
  end

  for (genvar j = 0; j < EnqWidth; j++) begin : g_lane
    prio_onehot_picker #(
      .Width (EntryCount),
      .RankW (RankW)
    ) u_picker (
      .vec    (free_set),
      .rank   (lane_rank[j]),
      .onehot (lane_pick[j])
    );

    assign alloc_fire_o[j] = alloc_req_i[j] & ~flush_i &
                             (32'(free_cnt_q) > 32'(lane_rank[j]));
    assign alloc_mask_o[j] = alloc_fire_o[j] ? lane_pick[j] : '0;
  end

  always_comb begin
    alloc_or = '0;
    for (int j = 0; j < EnqWidth; j++) alloc_or = alloc_or | alloc_mask_o[j];
  end

  always_comb begin
    free_or = '0;
    for (int p = 0; p < DeqWidth; p++) begin
      if (free_vld_i[p]) free_or = free_or | free_mask_i[p];
    end
  end

  assign deq_fire_o = (|free_vld_i) & ~flush_i;
  assign deq_mask_o = deq_fire_o ? free_or : '0;

  assign entry_vld_d = flush_i ? '0 : ((entry_vld_q | alloc_or) & ~deq_mask_o);

  always_comb begin
    int unsigned n;
    n = 0;
    for (int i = 0; i < EntryCount; i++) n = n + 32'(~entry_vld_d[i]);
    free_cnt_d = CntW'(n);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entry_vld_q <= '0;
      free_cnt_q  <= CntW'(EntryCount);
    end else begin
      entry_vld_q <= entry_vld_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  assign entry_vld_o = entry_vld_q;
  assign free_cnt_o  = free_cnt_q;
  assign full_o      = (free_cnt_q == '0);
  assign empty_o     = (free_cnt_q == CntW'(EntryCount));

  always_comb begin
    free_overlap = 1'b0;
    for (int p = 0; p < DeqWidth; p++) begin
      for (int q = p + 1; q < DeqWidth; q++) begin
        if (free_vld_i[p] && free_vld_i[q] && (|(free_mask_i[p] & free_mask_i[q])))
          free_overlap = 1'b1;
      end
    end
  end

  // Releasing an unallocated entry or double-freeing one is caller error.
  a_free_valid_entry : assert property (@(posedge clk) disable iff (!rstn)
    !flush_i |-> ((deq_mask_o & ~entry_vld_q) == '0));
  a_free_no_overlap : assert property (@(posedge clk) disable iff (!rstn)
    !flush_i |-> !free_overlap);

endmodule

`default_nettype wire

// File: tb/tb_iq_entry_allocator.sv
// ============================================================================
// tb_iq_entry_allocator : directed vectors with a queue-based scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_iq_entry_allocator;

  typedef struct packed {
    logic [1:0] fire;
    logic [3:0] m0;
    logic [3:0] m1;
    logic       dfire;
    logic [3:0] dmask;
    logic [3:0] nvld;
    logic [2:0] ncnt;
    logic       nfull;
    logic       nempty;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic [1:0]      alloc_req_i;
  logic [1:0]      alloc_fire_o;
  logic [1:0][3:0] alloc_mask_o;
  logic [1:0]      free_vld_i;
  logic [1:0][3:0] free_mask_i;
  logic            flush_i;
  logic            deq_fire_o;
  logic [3:0]      deq_mask_o;
  logic [3:0]      entry_vld_o;
  logic [2:0]      free_cnt_o;
  logic            full_o;
  logic            empty_o;

  int   vectors     = 0;
  int   miscompares = 0;
  logic stim_vld    = 1'b0;
  exp_t sb[$];

  iq_entry_allocator dut (
    .clk          (clk),
    .rstn         (rstn),
    .alloc_req_i  (alloc_req_i),
    .alloc_fire_o (alloc_fire_o),
    .alloc_mask_o (alloc_mask_o),
    .free_vld_i   (free_vld_i),
    .free_mask_i  (free_mask_i),
    .flush_i      (flush_i),
    .deq_fire_o   (deq_fire_o),
    .deq_mask_o   (deq_mask_o),
    .entry_vld_o  (entry_vld_o),
    .free_cnt_o   (free_cnt_o),
    .full_o       (full_o),
    .empty_o      (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic vec(input logic [1:0] req, input logic [1:0] fv,
                     input logic [3:0] fm0, input logic [3:0] fm1,
                     input logic fl, input exp_t e);
    @(negedge clk);
    alloc_req_i    = req;
    free_vld_i     = fv;
    free_mask_i[0] = fm0;
    free_mask_i[1] = fm1;
    flush_i        = fl;
    sb.push_back(e);
    stim_vld       = 1'b1;
  endtask

  // Monitor: combinational response mid-cycle, registered state after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (stim_vld) begin
        if (sb.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("alloc_fire", 32'(alloc_fire_o), 32'(e.fire));
          chk("alloc_mask0", 32'(alloc_mask_o[0]), 32'(e.m0));
          chk("alloc_mask1", 32'(alloc_mask_o[1]), 32'(e.m1));
          chk("deq_fire", 32'(deq_fire_o), 32'(e.dfire));
          chk("deq_mask", 32'(deq_mask_o), 32'(e.dmask));
          @(posedge clk);
          #1;
          chk("entry_vld", 32'(entry_vld_o), 32'(e.nvld));
          chk("free_cnt", 32'(free_cnt_o), 32'(e.ncnt));
          chk("full", 32'(full_o), 32'(e.nfull));
          chk("empty", 32'(empty_o), 32'(e.nempty));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn        = 1'b0;
    alloc_req_i = '0;
    free_vld_i  = '0;
    free_mask_i = '0;
    flush_i     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_entry_vld", 32'(entry_vld_o), 32'h0);
    chk("rst_free_cnt", 32'(free_cnt_o), 32'd4);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    //   req    fv     fm0      fm1      fl    fire   m0       m1       df    dmask    nvld     cnt   full  empty
    vec(2'b11, 2'b00, 4'b0000, 4'b0000, 1'b0, '{2'b11, 4'b0001, 4'b0010, 1'b0, 4'b0000, 4'b0011, 3'd2, 1'b0, 1'b0});
    vec(2'b01, 2'b00, 4'b0000, 4'b0000, 1'b0, '{2'b01, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0111, 3'd1, 1'b0, 1'b0});
    vec(2'b11, 2'b00, 4'b0000, 4'b0000, 1'b0, '{2'b01, 4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 3'd0, 1'b1, 1'b0});
    vec(2'b01, 2'b01, 4'b0010, 4'b0000, 1'b0, '{2'b00, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b1101, 3'd1, 1'b0, 1'b0});
    vec(2'b11, 2'b10, 4'b0000, 4'b0001, 1'b0, '{2'b01, 4'b0010, 4'b0000, 1'b1, 4'b0001, 4'b1110, 3'd1, 1'b0, 1'b0});
    vec(2'b00, 2'b11, 4'b0100, 4'b1000, 1'b0, '{2'b00, 4'b0000, 4'b0000, 1'b1, 4'b1100, 4'b0010, 3'd3, 1'b0, 1'b0});
    vec(2'b10, 2'b00, 4'b0000, 4'b0000, 1'b0, '{2'b10, 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0011, 3'd2, 1'b0, 1'b0});
    vec(2'b11, 2'b01, 4'b0001, 4'b0000, 1'b0, '{2'b11, 4'b0100, 4'b1000, 1'b1, 4'b0001, 4'b1110, 3'd1, 1'b0, 1'b0});
    vec(2'b00, 2'b01, 4'b0100, 4'b0000, 1'b0, '{2'b00, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b1010, 3'd2, 1'b0, 1'b0});
    vec(2'b11, 2'b01, 4'b0010, 4'b0000, 1'b1, '{2'b00, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b0, 1'b1});
    vec(2'b10, 2'b00, 4'b0000, 4'b0000, 1'b0, '{2'b10, 4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 3'd3, 1'b0, 1'b0});
    vec(2'b11, 2'b00, 4'b0000, 4'b0000, 1'b0, '{2'b11, 4'b0010, 4'b0100, 1'b0, 4'b0000, 4'b0111, 3'd1, 1'b0, 1'b0});
    vec(2'b00, 2'b01, 4'b0001, 4'b0000, 1'b0, '{2'b00, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0110, 3'd2, 1'b0, 1'b0});

    @(negedge clk);
    stim_vld    = 1'b0;
    alloc_req_i = '0;
    free_vld_i  = '0;
    free_mask_i = '0;
    flush_i     = 1'b0;

    // Asynchronous reset asserted mid-cycle must clear state before any edge.
    #3;
    rstn = 1'b0;
    #1;
    chk("async_entry_vld", 32'(entry_vld_o), 32'h0);
    chk("async_free_cnt", 32'(free_cnt_o), 32'd4);
    chk("async_full", 32'(full_o), 32'd0);
    chk("async_empty", 32'(empty_o), 32'd1);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
